// File: rtl/systola_pkg.sv
// Shared types and defaults for the column result writer.
package systola_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} wr_state_e;

  localparam int DW_DEF     = 32;
  localparam int AW_DEF     = 16;
  localparam int BURST_DEF  = 8;
  localparam int BURST_LOG2 = $clog2(BURST_DEF);
  localparam int NB_W       = 16;
endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO buffering column results ahead of the write port.
module result_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [PW-1:0]            wp, rp;
  logic [PW:0]              cnt;
  logic                     do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign dout    = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/col_result_writer.sv
// Pops column results into a FIFO and emits addressed, burst-delimited write beats.
module col_result_writer
  import systola_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int AW         = AW_DEF,
  parameter int BURST      = BURST_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [NB_W-1:0] num_bursts,
  input  logic [DW-1:0]   in_r,
  input  logic            in_rvalid,
  output logic            in_rread,
  output logic            wr_valid,
  input  logic            wr_ready,
  output logic [AW-1:0]   wr_addr,
  output logic [DW-1:0]   wr_data,
  output logic            wr_last,
  output logic            busy,
  output logic            done
);
  localparam int BL = $clog2(BURST);
  localparam int CW = NB_W + BL;

  wr_state_e         state;
  logic [AW-1:0]     base;
  logic [CW-1:0]     total, pushed, written;
  logic              full, empty, push, pop;

  // Request only while words are still owed and there is room to land them.
  assign in_rread = (state == RUN) && (pushed < total) && !full;
  assign push     = in_rvalid && in_rread;
  assign wr_valid = !empty;
  assign pop      = wr_valid && wr_ready;
  assign wr_addr  = base + AW'(written);
  assign wr_last  = wr_valid && (written[BL-1:0] == BL'(BURST-1));
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  result_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_r),
    .dout  (wr_data),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      base    <= '0;
      total   <= '0;
      pushed  <= '0;
      written <= '0;
    end else begin
      if (pop) written <= written + 1'b1;
      case (state)
        IDLE: if (start) begin
          base    <= base_addr;
          total   <= {num_bursts, BL'(0)};
          pushed  <= '0;
          written <= '0;
          state   <= (num_bursts != '0) ? RUN : DONE;
        end
        RUN: if (push) begin
          pushed <= pushed + 1'b1;
          if (pushed + 1'b1 == total) state <= DRAIN;
        end
        DRAIN: if (pop && (written + 1'b1 == total)) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_col_result_writer.sv
// Directed bench for col_result_writer: stalls, address wrap, empty jobs, mid-job reset.
module tb_col_result_writer;
  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   num_bursts = '0;
  logic [DW-1:0] in_r = '0;
  logic          in_rvalid = 1'b0;
  logic          wr_ready = 1'b0;
  logic          in_rread, wr_valid, wr_last, busy, done;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  always #5 clk = ~clk;

  col_result_writer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_bursts (num_bursts),
    .in_r       (in_r),
    .in_rvalid  (in_rvalid),
    .in_rread   (in_rread),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         beats[$];
  beat_t         prev;
  logic          stall_prev = 1'b0;
  logic          pop_pend = 1'b0;
  int            pop_cnt = 0, done_cnt = 0, rread_seen = 0, hold_err = 0;
  int            cyc = 0, first_acc = 0, last_acc = 0, done_cyc = 0;
  int            src_n = 0;
  logic [DW-1:0] seed = '0;
  int            checks = 0, errors = 0;

  // Monitor at negedge: handshakes seen here complete on the following posedge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (stall_prev && ({wr_addr, wr_data, wr_last} != prev)) hold_err++;
      stall_prev = wr_valid && !wr_ready;
      prev = {wr_addr, wr_data, wr_last};
    end else begin
      stall_prev = 1'b0;
    end
    if (in_rread) rread_seen++;
    if (in_rvalid && in_rread) begin
      pop_cnt++;
      pop_pend = 1'b1;
    end
    if (wr_valid && wr_ready) begin
      beats.push_back({wr_addr, wr_data, wr_last});
      if (beats.size() == 1) first_acc = cyc;
      last_acc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Column controller model: advance to the next word after each pop.
  initial forever begin
    @(posedge clk);
    #1;
    if (pop_pend) begin
      pop_pend = 1'b0;
      src_n++;
      in_r = seed + DW'(src_n);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic reset_src(input logic [DW-1:0] s);
    seed = s;
    src_n = 0;
    in_r = s;
    pop_pend = 1'b0;
    pop_cnt = 0;
    done_cnt = 0;
    rread_seen = 0;
    beats.delete();
  endtask

  task automatic go(input logic [AW-1:0] b, input logic [15:0] nb);
    base_addr = b;
    num_bursts = nb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (done_cnt == 0 && n < lim) begin
      tick();
      n++;
    end
    chk("done_seen", done_cnt != 0, 1);
  endtask

  task automatic chk_beats(input string tag, input logic [AW-1:0] b, input int n);
    logic [AW-1:0] ea;
    chk({tag, "_count"}, beats.size(), n);
    for (int i = 0; i < n && i < beats.size(); i++) begin
      ea = b + AW'(i);
      chk({tag, "_addr"}, beats[i].a, ea);
      chk({tag, "_data"}, beats[i].d, seed + DW'(i));
      chk({tag, "_last"}, beats[i].l, (i % 8) == 7);
    end
  endtask

  initial begin
    // 1: reset held while inputs toggle
    for (int i = 0; i < 6; i++) begin
      in_rvalid = i[0];
      wr_ready = ~i[0];
      tick();
    end
    chk("rst_rread", in_rread, 0);
    chk("rst_wvalid", wr_valid, 0);
    chk("rst_wlast", wr_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_pops", pop_cnt, 0);
    chk("rst_beats", beats.size(), 0);
    rst = 1'b0;
    tick(2);

    // 2: single burst, full throughput
    reset_src(32'h1000_0000);
    in_rvalid = 1'b1;
    wr_ready = 1'b1;
    go(16'h0100, 16'd1);
    chk("t2_busy", busy, 1);
    wait_done(40);
    tick(3);
    chk_beats("t2", 16'h0100, 8);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_done_lat", done_cyc - last_acc, 1);
    chk("t2_thruput", last_acc - first_acc, 7);
    chk("t2_pops", pop_cnt, 8);

    // 3: sink stalled, FIFO fills, then releases
    reset_src(32'h2000_0000);
    wr_ready = 1'b0;
    go(16'h0200, 16'd2);
    tick(10);
    chk("t3_pops_stall", pop_cnt, 4);
    chk("t3_rread_low", in_rread, 0);
    chk("t3_wvalid", wr_valid, 1);
    chk("t3_hold_addr", wr_addr, 16'h0200);
    chk("t3_hold_data", wr_data, 32'h2000_0000);
    wr_ready = 1'b1;
    wait_done(80);
    tick(2);
    chk_beats("t3", 16'h0200, 16);
    chk("t3_hold_err", hold_err, 0);
    chk("t3_pops", pop_cnt, 16);

    // 4: address wrap
    reset_src(32'h3000_0000);
    go(16'hFFFC, 16'd1);
    wait_done(40);
    tick(3);
    chk_beats("t4", 16'hFFFC, 8);

    // 5: empty job, then start while busy
    reset_src(32'h4000_0000);
    base_addr = 16'h0500;
    num_bursts = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("t5_done_hi", done, 1);
    tick();
    @(negedge clk);
    chk("t5_done_lo", done, 0);
    tick();
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_no_rread", rread_seen, 0);
    chk("t5_no_beats", beats.size(), 0);
    reset_src(32'h4100_0000);
    go(16'h0600, 16'd1);
    tick(2);
    chk("t5_busy", busy, 1);
    go(16'h0700, 16'd3);
    wait_done(40);
    tick(3);
    chk_beats("t5", 16'h0600, 8);
    chk("t5_done_once", done_cnt, 1);
    chk("t5_pops", pop_cnt, 8);

    // 6: reset in DRAIN, then a fresh job
    reset_src(32'h5000_0000);
    go(16'h0800, 16'd1);
    for (int n = 0; n < 30 && pop_cnt < 8; n++) tick();
    chk("t6_all_popped", pop_cnt, 8);
    wr_ready = 1'b0;
    chk("t6_drain_busy", busy, 1);
    chk("t6_drain_wvalid", wr_valid, 1);
    tick(2);
    rst = 1'b1;
    #1;
    chk("t6_wvalid", wr_valid, 0);
    chk("t6_rread", in_rread, 0);
    chk("t6_busy", busy, 0);
    chk("t6_addr", wr_addr, 0);
    chk("t6_data", wr_data, 0);
    chk("t6_last", wr_last, 0);
    tick(2);
    chk("t6_no_done", done_cnt, 0);
    rst = 1'b0;
    tick();
    reset_src(32'h6000_0000);
    wr_ready = 1'b1;
    go(16'h0000, 16'd1);
    wait_done(40);
    tick(3);
    chk_beats("t6", 16'h0000, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
